// File: rtl/fetch_queue_if.sv
// Handshake bundle between fetch (producer), the fetch queue and decode (consumer).
// The slave modport is the queue's view; master is the surrounding pipeline's view.
interface fetch_queue_if #(
    parameter int DEPTH  = 4,
    parameter int INSN_W = 32,
    parameter int PC_W   = 32
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              push_valid;
    logic              push_ready;
    logic [INSN_W-1:0] push_insn;
    logic [PC_W-1:0]   push_pc;
    logic              pop_valid;
    logic              pop_ready;
    logic [INSN_W-1:0] pop_insn;
    logic [PC_W-1:0]   pop_pc;
    logic [CNT_W-1:0]  count;

    modport master (
        output push_valid, push_insn, push_pc, pop_ready,
        input  push_ready, pop_valid, pop_insn, pop_pc, count
    );

    modport slave (
        input  push_valid, push_insn, push_pc, pop_ready,
        output push_ready, pop_valid, pop_insn, pop_pc, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Circular instruction fetch buffer between imem and decode; state updates on the falling clock edge.
// Define FETCH_QUEUE_BYPASS_EN to forward a push straight to pop_* when the queue is empty.
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int INSN_W = 32,
    parameter int PC_W   = 32
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          flush_i,
    fetch_queue_if.slave  q
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [INSN_W-1:0] insn_mem [DEPTH];
    logic [PC_W-1:0]   pc_mem   [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic full;
    logic empty;
    logic bypass;
    logic wr_en;
    logic rd_en;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // Ready depends only on occupancy, so a pop can never make room for a same-edge push.
    assign q.push_ready = ~full;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = empty & q.push_valid & ~flush_i;
`else
    assign bypass = 1'b0;
`endif

    assign q.pop_valid = ~empty | bypass;
    assign q.count     = count_q;

    always_comb begin
        q.pop_insn = '0;
        q.pop_pc   = '0;
        if (!empty) begin
            q.pop_insn = insn_mem[rd_ptr_q];
            q.pop_pc   = pc_mem[rd_ptr_q];
        end else if (bypass) begin
            q.pop_insn = q.push_insn;
            q.pop_pc   = q.push_pc;
        end
    end

    // A forwarded word taken by decode on the same edge never touches storage.
    assign wr_en = q.push_valid & ~full & ~flush_i & ~(bypass & q.pop_ready);
    assign rd_en = ~empty & q.pop_ready & ~flush_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end

    always_ff @(negedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is not reset; occupancy alone decides what is visible.
    always_ff @(negedge clock_i) begin
        if (wr_en) begin
            insn_mem[wr_ptr_q] <= q.push_insn;
            pc_mem[wr_ptr_q]   <= q.push_pc;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a queue-based reference model checked every cycle plus literal expectations.
// Follows FETCH_QUEUE_BYPASS_EN the same way the design does.
`timescale 1ns/1ps
module tb_fetch_queue;
    localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;

    fetch_queue_if #(.DEPTH(DEPTH), .INSN_W(32), .PC_W(32)) fq ();

    fetch_queue #(.DEPTH(DEPTH), .INSN_W(32), .PC_W(32)) dut (
        .clock_i (clock),
        .reset_i (reset),
        .flush_i (flush),
        .q       (fq)
    );

    always #10 clock = ~clock;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    // Model: entries held as {pc, insn}; head is element 0.
    logic [63:0] fifo [$];
    logic [63:0] got  [$];
    bit          exp_byp, exp_pv, exp_pr;
    logic [63:0] exp_head;
    int          exp_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void calc_exp();
        int n;
        n        = fifo.size();
        exp_byp  = BYP && (n == 0) && fq.push_valid && !flush;
        exp_pv   = (n != 0) || exp_byp;
        exp_pr   = (n < DEPTH);
        exp_cnt  = n;
        if (n != 0)       exp_head = fifo[0];
        else if (exp_byp) exp_head = {fq.push_pc, fq.push_insn};
        else              exp_head = '0;
    endfunction

    // Inputs change right after the rising edge; state moves on the falling edge.
    always begin
        @(posedge clock);
        #2;
        if (cmp_en) begin
            calc_exp();
            chk("count",      64'(fq.count),      64'(exp_cnt));
            chk("push_ready", 64'(fq.push_ready), 64'(exp_pr));
            chk("pop_valid",  64'(fq.pop_valid),  64'(exp_pv));
            chk("pop_head",   {fq.pop_pc, fq.pop_insn}, exp_head);
            if (fq.pop_valid && fq.pop_ready && !flush)
                got.push_back({fq.pop_pc, fq.pop_insn});
        end
    end

    task automatic cycle(input bit pv, input logic [31:0] insn, input logic [31:0] pc,
                         input bit pr, input bit fl);
        @(posedge clock);
        fq.push_valid = pv;
        fq.push_insn  = insn;
        fq.push_pc    = pc;
        fq.pop_ready  = pr;
        flush         = fl;
        #3;
        calc_exp();
        if (flush) begin
            fifo.delete();
        end else if (!(exp_byp && fq.pop_ready)) begin
            if (exp_pv && fq.pop_ready) void'(fifo.pop_front());
            if (fq.push_valid && exp_pr) fifo.push_back({fq.push_pc, fq.push_insn});
        end
        #1;
    endtask

    initial begin
        fq.push_valid = 1'b0;
        fq.push_insn  = '0;
        fq.push_pc    = '0;
        fq.pop_ready  = 1'b0;
        #1;
        chk("rst_count",      64'(fq.count),      64'd0);
        chk("rst_push_ready", 64'(fq.push_ready), 64'd1);
        chk("rst_pop_valid",  64'(fq.pop_valid),  64'd0);
        chk("rst_pop_insn",   64'(fq.pop_insn),   64'd0);
        #4 reset = 1'b1;
        cmp_en = 1'b1;

        // 1: async reset mid-run with three entries queued
        for (int i = 1; i <= 3; i++) cycle(1, 32'hE000_0000 + 32'(i), 32'(i), 0, 0);
        @(posedge clock);
        fq.push_valid = 1'b0;
        fq.pop_ready  = 1'b0;
        #4;
        chk("t1_pre_count", 64'(fq.count), 64'd3);
        #1 reset = 1'b0;
        #1;
        chk("t1_count",      64'(fq.count),      64'd0);
        chk("t1_pop_valid",  64'(fq.pop_valid),  64'd0);
        chk("t1_pop_insn",   64'(fq.pop_insn),   64'd0);
        chk("t1_push_ready", 64'(fq.push_ready), 64'd1);
        fifo.delete();
        #2 reset = 1'b1;

        // 2: fill to full, 5th push ignored, drain in order
        for (int i = 1; i <= 4; i++) cycle(1, 32'hAAAA_0000 + 32'(i), 32'(i), 0, 0);
        cycle(1, 32'hAAAA_0005, 32'd5, 0, 0);
        chk("t2_full_count", 64'(fq.count),      64'd4);
        chk("t2_full_ready", 64'(fq.push_ready), 64'd0);
        got.delete();
        for (int i = 0; i < 4; i++) cycle(0, '0, '0, 1, 0);
        cycle(0, '0, '0, 1, 0);
        chk("t2_drained_valid", 64'(fq.pop_valid), 64'd0);
        chk("t2_pop_n", 64'(got.size()), 64'd4);
        for (int i = 0; i < got.size(); i++)
            chk("t2_order", got[i], {32'(i + 1), 32'hAAAA_0000 + 32'(i + 1)});

        // 3: steady push+pop at count 2 across pointer wrap
        got.delete();
        cycle(1, 32'hB000_0000, 32'd100, 0, 0);
        cycle(1, 32'hB000_0001, 32'd101, 0, 0);
        for (int i = 2; i < 12; i++) begin
            cycle(1, 32'hB000_0000 + 32'(i), 32'd100 + 32'(i), 1, 0);
            chk("t3_count", 64'(fq.count), 64'd2);
        end
        chk("t3_pop_n", 64'(got.size()), 64'd10);
        for (int i = 0; i < got.size(); i++)
            chk("t3_order", got[i], {32'd100 + 32'(i), 32'hB000_0000 + 32'(i)});
        cycle(0, '0, '0, 1, 0);
        cycle(0, '0, '0, 1, 0);

        // 4: flush with simultaneous push and pop at count 3
        for (int i = 1; i <= 3; i++) cycle(1, 32'hC000_0000 + 32'(i), 32'(i), 0, 0);
        cycle(1, 32'hDEAD_BEEF, 32'd50, 1, 1);
        cycle(1, 32'hD000_0001, 32'd9, 0, 0);
        chk("t4_flushed_count", 64'(fq.count),     64'd0);
        chk("t4_flushed_valid", 64'(fq.pop_valid), 64'(BYP));
        got.delete();
        cycle(0, '0, '0, 1, 0);
        cycle(0, '0, '0, 1, 0);
        chk("t4_pop_n", 64'(got.size()), 64'd1);
        if (got.size() != 0) chk("t4_pop", got[0], {32'd9, 32'hD000_0001});

        // 5: pops on an empty queue do nothing
        for (int i = 0; i < 3; i++) begin
            cycle(0, '0, '0, 1, 0);
            chk("t5_count",    64'(fq.count),    64'd0);
            chk("t5_pop_insn", 64'(fq.pop_insn), 64'd0);
        end

        // 6: push into empty queue with decode ready
        cycle(1, 32'h1234_5678, 32'd7, 1, 0);
        chk("t6_valid", 64'(fq.pop_valid), 64'(BYP));
        chk("t6_insn",  64'(fq.pop_insn),  BYP ? 64'h1234_5678 : 64'd0);
        chk("t6_count", 64'(fq.count),     64'd0);
        cycle(0, '0, '0, 1, 0);
        chk("t6_next_count", 64'(fq.count),     BYP ? 64'd0 : 64'd1);
        chk("t6_next_valid", 64'(fq.pop_valid), BYP ? 64'd0 : 64'd1);
        chk("t6_next_insn",  64'(fq.pop_insn),  BYP ? 64'd0 : 64'h1234_5678);
        cycle(0, '0, '0, 1, 0);
        chk("t6_final_count", 64'(fq.count), 64'd0);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
